// File: rtl/dp_pkg.sv
// Shared types and default widths for the data-plane receive buffer.
package dp_pkg;

  localparam int DP_ID_W    = 16;
  localparam int DP_DATA_W  = 16;
  localparam int DP_DEPTH   = 16;
  localparam int DP_PKT_LEN = 5;

  typedef struct packed {
    logic [DP_ID_W-1:0]   dest;
    logic [DP_DATA_W-1:0] data;
  } dp_packet_t;

  typedef enum logic [1:0] {IDLE, ACCEPT, DROP} rx_state_t;

endpackage

// File: rtl/dp_rx_ram.sv
// Simple dual-port payload store: one synchronous write port, one registered read port.
module dp_rx_ram
  import dp_pkg::*;
#(
  parameter int DEPTH  = DP_DEPTH,
  parameter int DATA_W = DP_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Only the read register is reset; the array itself keeps no defined contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/data_plane_rx_fifo.sv
// Receive buffer: filters packets on destination id, frames fixed-length messages
// into a circular FIFO (whole message accepted or dropped) and serves GPP pops.
module data_plane_rx_fifo
  import dp_pkg::*;
#(
  parameter int ID_W    = DP_ID_W,
  parameter int DATA_W  = DP_DATA_W,
  parameter int DEPTH   = DP_DEPTH,
  parameter int PKT_LEN = DP_PKT_LEN
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rx_valid,
  input  logic [ID_W+DATA_W-1:0] rx_packet,
  input  logic [ID_W-1:0]        node_id,
  input  logic                   gpp_rd_req,
  input  logic                   clear_ovf,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   rd_valid,
  output logic                   rx_complete,
  output logic [$clog2(DEPTH):0] msg_count,
  output logic [$clog2(DEPTH):0] word_count,
  output logic                   empty,
  output logic                   overflow
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int WORD_W = $clog2(PKT_LEN);
  localparam logic [WORD_W-1:0] LAST_WORD   = WORD_W'(PKT_LEN - 1);
  localparam logic [ADDR_W:0]   SPACE_LIMIT = (ADDR_W + 1)'(DEPTH - PKT_LEN);

  rx_state_t         state;
  logic [WORD_W-1:0] rx_word;
  logic [WORD_W-1:0] rd_word;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              match;
  logic              has_space;
  logic              wr_en;
  logic              pop;
  logic              rx_last;
  logic              rd_last;

  // Space is judged on the registered count so a same-cycle pop never helps admission.
  assign match     = rx_valid && (rx_packet[ID_W+DATA_W-1:DATA_W] == node_id);
  assign has_space = (word_count <= SPACE_LIMIT);
  assign empty     = (word_count == '0);
  assign pop       = gpp_rd_req && !empty;
  assign wr_en     = match && (((state == IDLE) && has_space) || (state == ACCEPT));
  assign rx_last   = match && (state == ACCEPT) && (rx_word == LAST_WORD);
  assign rd_last   = pop && (rd_word == LAST_WORD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rx_word     <= '0;
      overflow    <= 1'b0;
      rx_complete <= 1'b0;
    end else begin
      rx_complete <= rx_last;
      if (clear_ovf) overflow <= 1'b0;
      if (match) begin
        unique case (state)
          IDLE: begin
            rx_word <= WORD_W'(1);
            if (has_space) begin
              state <= ACCEPT;
            end else begin
              state    <= DROP;
              overflow <= 1'b1;
            end
          end
          ACCEPT, DROP: begin
            if (rx_word == LAST_WORD) begin
              state   <= IDLE;
              rx_word <= '0;
            end else begin
              rx_word <= rx_word + 1'b1;
            end
          end
          default: begin
            state   <= IDLE;
            rx_word <= '0;
          end
        endcase
      end
    end
  end

  // Pointers wrap naturally at ADDR_W bits; counters are one bit wider to hold DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rd_word    <= '0;
      rd_valid   <= 1'b0;
      word_count <= '0;
      msg_count  <= '0;
    end else begin
      rd_valid <= pop;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_word <= rd_last ? '0 : rd_word + 1'b1;
      end
      case ({wr_en, pop})
        2'b10:   word_count <= word_count + 1'b1;
        2'b01:   word_count <= word_count - 1'b1;
        default: word_count <= word_count;
      endcase
      case ({rx_last, rd_last})
        2'b10:   msg_count <= msg_count + 1'b1;
        2'b01:   msg_count <= msg_count - 1'b1;
        default: msg_count <= msg_count;
      endcase
    end
  end

  dp_rx_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (rx_packet[DATA_W-1:0]),
    .rd_en   (pop),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_data_plane_rx_fifo.sv
// Self-checking bench for data_plane_rx_fifo: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based reference model.
module tb_data_plane_rx_fifo;
  import dp_pkg::*;

  localparam int ID_W    = 16;
  localparam int DATA_W  = 16;
  localparam int DEPTH   = 16;
  localparam int PKT_LEN = 5;
  localparam logic [ID_W-1:0] NODE  = 16'd3;
  localparam logic [ID_W-1:0] OTHER = 16'd7;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   rx_valid = 1'b0;
  logic [ID_W+DATA_W-1:0] rx_packet = '0;
  logic [ID_W-1:0]        node_id = NODE;
  logic                   gpp_rd_req = 1'b0;
  logic                   clear_ovf = 1'b0;
  logic [DATA_W-1:0]      rd_data;
  logic                   rd_valid;
  logic                   rx_complete;
  logic [4:0]             msg_count;
  logic [4:0]             word_count;
  logic                   empty;
  logic                   overflow;

  always #5 clk = ~clk;

  data_plane_rx_fifo #(
    .ID_W(ID_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .PKT_LEN(PKT_LEN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_packet(rx_packet),
    .node_id(node_id), .gpp_rd_req(gpp_rd_req), .clear_ovf(clear_ovf),
    .rd_data(rd_data), .rd_valid(rd_valid), .rx_complete(rx_complete),
    .msg_count(msg_count), .word_count(word_count), .empty(empty), .overflow(overflow)
  );

  int check_count = 0;
  int error_count = 0;

  // Reference model: the FIFO is a queue, messages are tracked by counts only.
  logic [DATA_W-1:0] model_q[$];
  int                msg_words_seen = 0;
  bit                msg_dropping = 0;
  int                msgs_completed = 0;
  int                words_popped = 0;
  bit                exp_ovf = 0;
  bit                exp_rdv = 0;
  bit                exp_cmp = 0;
  logic [DATA_W-1:0] exp_rd_data = '0;

  typedef struct {
    logic        v;
    logic [15:0] dest;
    logic [15:0] data;
    logic        rd;
    int          exp_wc;
    int          exp_mc;
    logic        exp_cmp;
    logic        exp_rdv;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vecs[15];

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("[TB] FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic modelReset();
    model_q.delete();
    msg_words_seen = 0;
    msg_dropping   = 0;
    msgs_completed = 0;
    words_popped   = 0;
    exp_ovf        = 0;
    exp_rdv        = 0;
    exp_cmp        = 0;
    exp_rd_data    = '0;
  endtask

  task automatic modelStep(input logic v, input logic [15:0] dest, input logic [15:0] data,
                           input logic rd, input logic clr);
    int sz = model_q.size();
    bit pop_now = rd && (sz != 0);
    bit set_ovf = 0;
    exp_cmp = 0;
    if (pop_now) exp_rd_data = model_q[0];
    if (v && dest == NODE) begin
      if (msg_words_seen == 0) begin
        msg_dropping = (DEPTH - sz) < PKT_LEN;
        set_ovf      = msg_dropping;
      end
      if (!msg_dropping) model_q.push_back(data);
      msg_words_seen++;
      if (msg_words_seen == PKT_LEN) begin
        msg_words_seen = 0;
        if (!msg_dropping) begin
          msgs_completed++;
          exp_cmp = 1;
        end
      end
    end
    if (pop_now) begin
      void'(model_q.pop_front());
      words_popped++;
    end
    if (clr) exp_ovf = 0;
    if (set_ovf) exp_ovf = 1;
    exp_rdv = pop_now;
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, ".word_count"}, 32'(word_count), 32'(model_q.size()));
    checkOutput({tag, ".msg_count"}, 32'(msg_count), 32'(msgs_completed - words_popped / PKT_LEN));
    checkOutput({tag, ".empty"}, 32'(empty), 32'(model_q.size() == 0));
    checkOutput({tag, ".overflow"}, 32'(overflow), 32'(exp_ovf));
    checkOutput({tag, ".rx_complete"}, 32'(rx_complete), 32'(exp_cmp));
    checkOutput({tag, ".rd_valid"}, 32'(rd_valid), 32'(exp_rdv));
    if (exp_rdv) checkOutput({tag, ".rd_data"}, 32'(rd_data), 32'(exp_rd_data));
  endtask

  // Drives one cycle of inputs, advances the model at the edge, checks 1 ns later.
  task automatic applyStimulus(input logic v, input logic [15:0] dest, input logic [15:0] data,
                               input logic rd, input logic clr, input string tag);
    dp_packet_t pkt;
    pkt.dest   = dest;
    pkt.data   = data;
    rx_valid   = v;
    rx_packet  = pkt;
    gpp_rd_req = rd;
    clear_ovf  = clr;
    @(posedge clk);
    modelStep(v, dest, data, rd, clr);
    #1;
    rx_valid   = 1'b0;
    gpp_rd_req = 1'b0;
    clear_ovf  = 1'b0;
    checkModel(tag);
  endtask

  task automatic doReset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkModel(tag);
    checkOutput({tag, ".rd_data"}, 32'(rd_data), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{1'b1, NODE,  16'hA001, 1'b0, 1, 0, 1'b0, 1'b0, 16'h0};
    vecs[1]  = '{1'b1, OTHER, 16'hB001, 1'b0, 1, 0, 1'b0, 1'b0, 16'h0};
    vecs[2]  = '{1'b1, NODE,  16'hA002, 1'b0, 2, 0, 1'b0, 1'b0, 16'h0};
    vecs[3]  = '{1'b1, OTHER, 16'hB002, 1'b0, 2, 0, 1'b0, 1'b0, 16'h0};
    vecs[4]  = '{1'b1, NODE,  16'hA003, 1'b0, 3, 0, 1'b0, 1'b0, 16'h0};
    vecs[5]  = '{1'b1, NODE,  16'hA004, 1'b0, 4, 0, 1'b0, 1'b0, 16'h0};
    vecs[6]  = '{1'b1, OTHER, 16'hB003, 1'b0, 4, 0, 1'b0, 1'b0, 16'h0};
    vecs[7]  = '{1'b1, NODE,  16'hA005, 1'b0, 5, 1, 1'b1, 1'b0, 16'h0};
    vecs[8]  = '{1'b0, NODE,  16'h0000, 1'b0, 5, 1, 1'b0, 1'b0, 16'h0};
    vecs[9]  = '{1'b0, NODE,  16'h0000, 1'b1, 4, 1, 1'b0, 1'b1, 16'hA001};
    vecs[10] = '{1'b0, NODE,  16'h0000, 1'b1, 3, 1, 1'b0, 1'b1, 16'hA002};
    vecs[11] = '{1'b0, NODE,  16'h0000, 1'b1, 2, 1, 1'b0, 1'b1, 16'hA003};
    vecs[12] = '{1'b0, NODE,  16'h0000, 1'b1, 1, 1, 1'b0, 1'b1, 16'hA004};
    vecs[13] = '{1'b0, NODE,  16'h0000, 1'b1, 0, 0, 1'b0, 1'b1, 16'hA005};
    vecs[14] = '{1'b0, NODE,  16'h0000, 1'b1, 0, 0, 1'b0, 1'b0, 16'h0};

    // Reset, then address filter and in-order readback from the vector table.
    doReset("reset0");
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].v, vecs[i].dest, vecs[i].data, vecs[i].rd, 1'b0, "filter");
      checkOutput("vec.word_count", 32'(word_count), 32'(vecs[i].exp_wc));
      checkOutput("vec.msg_count", 32'(msg_count), 32'(vecs[i].exp_mc));
      checkOutput("vec.rx_complete", 32'(rx_complete), 32'(vecs[i].exp_cmp));
      checkOutput("vec.rd_valid", 32'(rd_valid), 32'(vecs[i].exp_rdv));
      if (vecs[i].exp_rdv) checkOutput("vec.rd_data", 32'(rd_data), 32'(vecs[i].exp_rd));
    end

    // Overflow: three messages fill 15 words, the fourth is dropped whole.
    for (int m = 0; m < 3; m++)
      for (int w = 0; w < PKT_LEN; w++)
        applyStimulus(1'b1, NODE, 16'(16'h1000 + m * 16 + w), 1'b0, 1'b0, "fill");
    for (int w = 0; w < PKT_LEN; w++) begin
      applyStimulus(1'b1, NODE, 16'(16'hD000 + w), 1'b0, 1'b0, "drop");
      checkOutput("drop.rx_complete", 32'(rx_complete), 32'h0);
      checkOutput("drop.word_count", 32'(word_count), 32'd15);
    end
    checkOutput("drop.overflow", 32'(overflow), 32'h1);
    checkOutput("drop.msg_count", 32'(msg_count), 32'd3);
    applyStimulus(1'b0, NODE, 16'h0, 1'b0, 1'b1, "clear");
    checkOutput("clear.overflow", 32'(overflow), 32'h0);
    for (int i = 0; i < 15; i++) applyStimulus(1'b0, NODE, 16'h0, 1'b1, 1'b0, "drain1");

    // Simultaneous write and pop while a completed message is being read out.
    for (int w = 0; w < PKT_LEN; w++) applyStimulus(1'b1, NODE, 16'(16'hC000 + w), 1'b0, 1'b0, "msgA");
    for (int w = 0; w < PKT_LEN - 1; w++) applyStimulus(1'b1, NODE, 16'(16'hE000 + w), 1'b1, 1'b0, "overlap");
    checkOutput("sim.pre_msg_count", 32'(msg_count), 32'd1);
    applyStimulus(1'b1, NODE, 16'hE004, 1'b1, 1'b0, "sim");
    checkOutput("sim.msg_count", 32'(msg_count), 32'd1);
    checkOutput("sim.word_count", 32'(word_count), 32'd5);
    checkOutput("sim.rx_complete", 32'(rx_complete), 32'h1);
    checkOutput("sim.rd_data", 32'(rd_data), 32'hC004);
    for (int i = 0; i < PKT_LEN; i++) applyStimulus(1'b0, NODE, 16'h0, 1'b1, 1'b0, "drain2");

    // Wrap-around: continuous write with concurrent pops.
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, NODE, 16'($urandom), 1'b1, 1'b0, "wrap");
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, NODE, 16'h0, 1'b1, 1'b0, "drain3");
    checkOutput("wrap.empty", 32'(empty), 32'h1);

    // Randomized traffic with filtering, drops, clears and partial reads.
    for (int i = 0; i < 600; i++) begin
      logic v   = ($urandom_range(0, 9) < 7);
      logic rd  = ($urandom_range(0, 9) < 4);
      logic clr = ($urandom_range(0, 19) == 0);
      logic [15:0] dest = ($urandom_range(0, 3) == 0) ? OTHER : NODE;
      applyStimulus(v, dest, 16'($urandom), rd, clr, "rand");
    end

    // Reset in the middle of a message: framing restarts from word 0.
    doReset("reset1");
    applyStimulus(1'b1, NODE, 16'h5000, 1'b0, 1'b0, "part");
    applyStimulus(1'b1, NODE, 16'h5001, 1'b0, 1'b0, "part");
    doReset("reset2");
    for (int w = 0; w < PKT_LEN; w++) begin
      applyStimulus(1'b1, NODE, 16'(16'h6000 + w), 1'b0, 1'b0, "reframe");
      checkOutput("reframe.rx_complete", 32'(rx_complete), 32'(w == PKT_LEN - 1));
    end
    checkOutput("reframe.msg_count", 32'(msg_count), 32'd1);
    checkOutput("reframe.word_count", 32'(word_count), 32'd5);
    applyStimulus(1'b0, NODE, 16'h0, 1'b1, 1'b0, "reframe_pop");
    checkOutput("reframe.rd_data", 32'(rd_data), 32'h6000);

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
